uart_rx_cfg: RTL

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_fifo.sv | 43 ++++
 rtl/uart_rx_cfg.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and receiver state encoding shared by the UART blocks
package uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO with occupancy level and a drop indication when full
module uart_rx_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop_req,
  output logic [W-1:0]  dout,
  output logic          valid,
  output logic [LW-1:0] level,
  output logic          drop
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop, wr, full;
  assign full  = level == LW'(DEPTH);
  assign valid = level != '0;
  assign pop   = pop_req && valid;
  assign wr    = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = valid ? mem[rp] : '0;
  // storage: a full FIFO only accepts a word when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      wp    <= wr ? wp + AW'(1) : wp;
      rp    <= pop ? rp + AW'(1) : rp;
      level <= level + LW'(wr) - LW'(pop);
    end
  end
endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable 16x-oversampling UART receiver feeding a show-ahead FIFO
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_perr,
  output logic                 m_ferr,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  output logic                 break_det,
  output logic [LW-1:0]        fifo_level
);
  localparam int DIV = CLK_FREQ / (BAUD * 16);
  localparam int DW  = $clog2(DIV);
  localparam int FW  = DATA_BITS + 2;
  rx_state_t state, next;
  logic rx_s1, rx_s2, rx_d, fall;
  logic [DW-1:0] div_cnt;
  logic [3:0] os, bit_cnt;
  logic [1:0] smp;
  logic tick, vt, bend, vote, last_stop, ferr_now, perr_w;
  logic par_acc, ferr_acc, zero_acc, push, brk, drop;
  logic [DATA_BITS-1:0] shreg;
  logic [FW-1:0] head;
  assign fall      = rx_d & ~rx_s2;
  assign tick      = div_cnt == DW'(DIV - 1);
  assign vt        = tick && os == 4'd9;
  assign bend      = tick && os == 4'd15;
  assign vote      = (smp[0] & smp[1]) | (smp[0] & rx_s2) | (smp[1] & rx_s2);
  assign last_stop = bit_cnt == 4'(STOP_BITS - 1);
  assign ferr_now  = ferr_acc | ~vote;
  assign perr_w    = PARITY == PAR_EVEN ? par_acc : PARITY == PAR_ODD ? ~par_acc : 1'b0;
  // rx synchronizer plus one extra stage for falling-edge detection, idle-high after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) {rx_s1, rx_s2, rx_d} <= 3'b111;
    else {rx_s1, rx_s2, rx_d} <= {rx, rx_s1, rx_s2};
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  end
  // next state; the word is pushed at the last stop-bit vote so the line can re-arm mid-stop
  always_comb begin
    next = state;
    push = 1'b0;
    brk  = 1'b0;
    case (state)
      S_IDLE:      next = fall ? S_START : S_IDLE;
      S_START:     next = (vt && vote) ? S_IDLE : bend ? S_DATA : S_START;
      S_DATA:      next = (bend && bit_cnt == 4'(DATA_BITS - 1)) ? (PARITY != PAR_NONE ? S_PARITY : S_STOP) : S_DATA;
      S_PARITY:    next = bend ? S_STOP : S_PARITY;
      S_STOP: begin
        push = vt && last_stop;
        brk  = push && zero_acc && !vote;
        next = push ? (ferr_now ? S_WAIT_IDLE : S_IDLE) : S_STOP;
      end
      S_WAIT_IDLE: next = rx_s2 ? S_IDLE : S_WAIT_IDLE;
      default:     next = S_IDLE;
    endcase
  end
  // oversample timing, bit sampling and per-frame accumulators; the divider restarts on a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      os       <= '0;
      smp      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_acc  <= 1'b0;
      ferr_acc <= 1'b0;
      zero_acc <= 1'b0;
    end else begin
      div_cnt <= ((state == S_IDLE && fall) || tick) ? '0 : div_cnt + DW'(1);
      os      <= (state == S_IDLE && fall) ? 4'd0 : tick ? os + 4'd1 : os;
      if (tick && os == 4'd7) smp[0] <= rx_s2;
      if (tick && os == 4'd8) smp[1] <= rx_s2;
      bit_cnt <= (state != next) ? 4'd0 : bend ? bit_cnt + 4'd1 : bit_cnt;
      if (vt && state == S_DATA) shreg <= {vote, shreg[DATA_BITS-1:1]};
      if (state == S_IDLE) begin
        par_acc  <= 1'b0;
        ferr_acc <= 1'b0;
        zero_acc <= 1'b1;
      end else if (vt && (state == S_DATA || state == S_PARITY)) begin
        par_acc  <= par_acc ^ vote;
        zero_acc <= zero_acc & ~vote;
      end else if (vt && state == S_STOP) begin
        ferr_acc <= ferr_now;
        zero_acc <= zero_acc & ~vote;
      end
    end
  end
  // single-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      break_det <= 1'b0;
    end else begin
      overrun   <= drop;
      break_det <= brk;
    end
  end
  uart_rx_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .din     ({shreg, perr_w, ferr_now}),
    .pop_req (m_ready),
    .dout    (head),
    .valid   (m_valid),
    .level   (fifo_level),
    .drop    (drop)
  );
  assign m_data = head[FW-1:2];
  assign m_perr = head[1];
  assign m_ferr = head[0];
endmodule
